// File: rtl/frame_sequencer.sv
// frame_sequencer: 512 Hz frame sequencer producing length, sweep and envelope ticks.
// Define FRAME_SEQ_EXT_DIV_EN to step on falling edges of div_bit instead of the internal prescaler.
module frame_sequencer #(
    parameter int DIV_COUNT = 8192
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       apu_on,
    input  logic       div_bit,
    output logic       length_tick,
    output logic       sweep_tick,
    output logic       env_tick,
    output logic [2:0] step
);
    logic ev;
`ifdef FRAME_SEQ_EXT_DIV_EN
    logic div_hist;
    assign ev = apu_on && div_hist && !div_bit;
    // History follows div_bit even while powered off so re-enable never sees a stale edge.
    always_ff @(posedge clk or posedge reset)
        if (reset) div_hist <= 1'b0;
        else div_hist <= div_bit;
`else
    localparam int PW = $clog2(DIV_COUNT);
    logic [PW-1:0] pre;
    logic unused_div_bit;
    assign unused_div_bit = div_bit;
    assign ev = apu_on && pre == PW'(DIV_COUNT - 1);
    always_ff @(posedge clk or posedge reset)
        if (reset) pre <= '0;
        else if (!apu_on || ev) pre <= '0;
        else pre <= pre + PW'(1);
`endif
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            length_tick <= 1'b0;
            sweep_tick  <= 1'b0;
            env_tick    <= 1'b0;
            step        <= 3'd0;
        end else if (!apu_on) begin
            length_tick <= 1'b0;
            sweep_tick  <= 1'b0;
            env_tick    <= 1'b0;
            step        <= 3'd0;
        end else begin
            length_tick <= ev && !step[0];
            sweep_tick  <= ev && step[1:0] == 2'b10;
            env_tick    <= ev && step == 3'd7;
            if (ev) step <= step + 3'd1;
        end
endmodule
